// File: rtl/ether_frame_gen.sv
// rtl/ether_frame_gen.sv - AXI-Stream Ethernet II + IPv4 frame source with backpressure, bursts and gap
module ether_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 11,
  parameter int CNT_W      = 16,
  parameter int GAP_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [CNT_W-1:0]        i_num_frames,
  input  logic [LEN_W-1:0]        i_payload_len,
  input  logic [GAP_W-1:0]        i_gap_cycles,
  input  logic [47:0]             i_dst_mac,
  input  logic [47:0]             i_src_mac,
  input  logic [31:0]             i_src_ip,
  input  logic [31:0]             i_dst_ip,
  input  logic [7:0]              i_protocol,
  output logic [DATA_WIDTH-1:0]   o_tdata,
  output logic [DATA_WIDTH/8-1:0] o_tkeep,
  output logic                    o_tvalid,
  output logic                    o_tlast,
  input  logic                    i_tready,
  output logic                    o_busy,
  output logic [CNT_W-1:0]        o_frames_sent
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = LEN_W + 1;
  localparam int HDR_N = 34;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic [CNT_W-1:0]      frame_id_q, frame_id_d;
  logic [CNT_W-1:0]      frames_sent_q, frames_sent_d;
  logic                  cont_q, cont_d;
  logic                  stop_q, stop_d;
  logic [GAP_W-1:0]      gap_len_q, gap_len_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]      pay_len_q, pay_len_d;
  logic [IDX_W-1:0]      flen_q, flen_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            hdr_q [HDR_N];
  logic [7:0]            hdr_d [HDR_N];
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]      tkeep_q, tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;

  logic [LEN_W-1:0]      pay_new;
  logic [IDX_W-1:0]      flen_new;
  logic [15:0]           tot_len;
  logic [15:0]           csum;
  logic [19:0]           csum_sum;
  logic [16:0]           csum_f1;
  logic [7:0]            hdr_new [HDR_N];

  logic                  load;
  logic [LEN_W-1:0]      src_len;
  logic [IDX_W-1:0]      src_flen;
  logic [IDX_W-1:0]      nidx;
  logic [IDX_W-1:0]      k;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [BYTES-1:0]      beat_keep;
  logic                  beat_last;
  logic                  hs;

  // Header image built from the live config inputs; only captured in LOAD.
  always_comb begin
    pay_new = (i_payload_len > LEN_W'(1480)) ? LEN_W'(1480) : i_payload_len;
    flen_new = IDX_W'(HDR_N) + {1'b0, pay_new};
    if (flen_new < IDX_W'(60)) flen_new = IDX_W'(60);
    tot_len = 16'(pay_new) + 16'd20;
    csum_sum = 20'h04500 + 20'(tot_len) + 20'(frame_id_q[15:0]) + 20'h04000
             + {4'h0, 8'h40, i_protocol}
             + 20'(i_src_ip[31:16]) + 20'(i_src_ip[15:0])
             + 20'(i_dst_ip[31:16]) + 20'(i_dst_ip[15:0]);
    csum_f1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
    csum = ~(csum_f1[15:0] + 16'(csum_f1[16]));
    for (int b = 0; b < 6; b++) begin
      hdr_new[b]     = i_dst_mac[47-8*b -: 8];
      hdr_new[6+b]   = i_src_mac[47-8*b -: 8];
    end
    hdr_new[12] = 8'h08;
    hdr_new[13] = 8'h00;
    hdr_new[14] = 8'h45;
    hdr_new[15] = 8'h00;
    hdr_new[16] = tot_len[15:8];
    hdr_new[17] = tot_len[7:0];
    hdr_new[18] = frame_id_q[15:8];
    hdr_new[19] = frame_id_q[7:0];
    hdr_new[20] = 8'h40;
    hdr_new[21] = 8'h00;
    hdr_new[22] = 8'h40;
    hdr_new[23] = i_protocol;
    hdr_new[24] = csum[15:8];
    hdr_new[25] = csum[7:0];
    for (int b = 0; b < 4; b++) begin
      hdr_new[26+b] = i_src_ip[31-8*b -: 8];
      hdr_new[30+b] = i_dst_ip[31-8*b -: 8];
    end
  end

  // Next beat: in LOAD the frame starts from the header being captured this cycle.
  always_comb begin
    load      = (state_q == S_LOAD);
    src_len   = load ? pay_new : pay_len_q;
    src_flen  = load ? flen_new : flen_q;
    nidx      = load ? '0 : idx_q + IDX_W'(BYTES);
    beat_data = '0;
    beat_keep = '0;
    k         = '0;
    for (int j = 0; j < BYTES; j++) begin
      k = nidx + IDX_W'(j);
      if (k < src_flen) begin
        beat_keep[BYTES-1-j] = 1'b1;
        if (k < IDX_W'(HDR_N)) begin
          beat_data[DATA_WIDTH-1-8*j -: 8] = load ? hdr_new[k[5:0]] : hdr_q[k[5:0]];
        end else if (k < IDX_W'(HDR_N) + {1'b0, src_len}) begin
          beat_data[DATA_WIDTH-1-8*j -: 8] = k[7:0] - 8'd34 + frame_id_q[7:0];
        end
      end
    end
    beat_last = (nidx + IDX_W'(BYTES)) >= src_flen;
  end

  always_comb begin
    hs            = tvalid_q & i_tready;
    state_d       = state_q;
    remain_d      = remain_q;
    frame_id_d    = frame_id_q;
    frames_sent_d = frames_sent_q;
    cont_d        = cont_q;
    stop_d        = stop_q;
    gap_len_d     = gap_len_q;
    gap_cnt_d     = gap_cnt_q;
    pay_len_d     = pay_len_q;
    flen_d        = flen_q;
    idx_d         = idx_q;
    hdr_d         = hdr_q;
    tdata_d       = tdata_q;
    tkeep_d       = tkeep_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    if (i_stop && state_q != S_IDLE) stop_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          remain_d = i_num_frames;
          cont_d   = (i_num_frames == '0);
          stop_d   = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        hdr_d     = hdr_new;
        pay_len_d = pay_new;
        flen_d    = flen_new;
        gap_len_d = i_gap_cycles;
        idx_d     = '0;
        tdata_d   = beat_data;
        tkeep_d   = beat_keep;
        tlast_d   = beat_last;
        tvalid_d  = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (hs && tlast_q) begin
          frames_sent_d = frames_sent_q + 1'b1;
          frame_id_d    = frame_id_q + 1'b1;
          if (!cont_q) remain_d = remain_q - 1'b1;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tdata_d  = '0;
          tkeep_d  = '0;
          if ((!cont_q && remain_q == CNT_W'(1)) || stop_q || i_stop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else if (gap_len_q != '0) begin
            gap_cnt_d = gap_len_q;
            state_d   = S_GAP;
          end else begin
            state_d = S_LOAD;
          end
        end else if (hs) begin
          idx_d   = nidx;
          tdata_d = beat_data;
          tkeep_d = beat_keep;
          tlast_d = beat_last;
        end
      end
      default: begin
        if (stop_q || i_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      remain_q      <= '0;
      frame_id_q    <= '0;
      frames_sent_q <= '0;
      cont_q        <= 1'b0;
      stop_q        <= 1'b0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      pay_len_q     <= '0;
      flen_q        <= '0;
      idx_q         <= '0;
      for (int i = 0; i < HDR_N; i++) hdr_q[i] <= '0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      frame_id_q    <= frame_id_d;
      frames_sent_q <= frames_sent_d;
      cont_q        <= cont_d;
      stop_q        <= stop_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      pay_len_q     <= pay_len_d;
      flen_q        <= flen_d;
      idx_q         <= idx_d;
      hdr_q         <= hdr_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      busy_q        <= busy_d;
    end
  end

  assign o_tdata       = tdata_q;
  assign o_tkeep       = tkeep_q;
  assign o_tvalid      = tvalid_q;
  assign o_tlast       = tlast_q;
  assign o_busy        = busy_q;
  assign o_frames_sent = frames_sent_q;

endmodule

// File: tb/tb_ether_frame_gen.sv
// tb/tb_ether_frame_gen.sv - directed vector bench for ether_frame_gen at 32 and 64 bit widths
module tb_ether_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s32 = 1'b0, s64 = 1'b0, stop = 1'b0, tready = 1'b1;
  logic [15:0] num_frames = 16'd1;
  logic [10:0] pay_len = 11'd26;
  logic [7:0]  gap = 8'd0;
  logic [47:0] dmac = 48'h0200_0000_0002, smac = 48'h0200_0000_0001;
  logic [31:0] sip = 32'h0A00_0001, dip = 32'h0A00_0002;
  logic [7:0]  proto = 8'd6;

  logic [31:0] d32; logic [3:0] k32; logic v32, l32, b32; logic [15:0] fs32;
  logic [63:0] d64; logic [7:0] k64; logic v64, l64, b64; logic [15:0] fs64;

  ether_frame_gen #(.DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .i_start(s32), .i_stop(stop), .i_num_frames(num_frames),
    .i_payload_len(pay_len), .i_gap_cycles(gap), .i_dst_mac(dmac), .i_src_mac(smac),
    .i_src_ip(sip), .i_dst_ip(dip), .i_protocol(proto), .o_tdata(d32), .o_tkeep(k32),
    .o_tvalid(v32), .o_tlast(l32), .i_tready(tready), .o_busy(b32), .o_frames_sent(fs32));

  ether_frame_gen #(.DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .i_start(s64), .i_stop(stop), .i_num_frames(num_frames),
    .i_payload_len(pay_len), .i_gap_cycles(gap), .i_dst_mac(dmac), .i_src_mac(smac),
    .i_src_ip(sip), .i_dst_ip(dip), .i_protocol(proto), .o_tdata(d64), .o_tkeep(k64),
    .o_tvalid(v64), .o_tlast(l64), .i_tready(tready), .o_busy(b64), .o_frames_sent(fs64));

  typedef struct {
    int          len;
    int          beats;
    logic [7:0]  lkeep;
    logic [15:0] tot;
    logic [15:0] csum;
  } vec_t;

  int total = 0, bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] want_q[$];
  int fstart_q[$];
  int gaps_q[$];
  int n_beats, n_tlast, stall_err, holes, busy_lag;
  logic [7:0] last_keep;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic void add_frame(int len, int id);
    logic [7:0] f[$];
    int plen, flen;
    logic [31:0] s;
    logic [15:0] tl, cs;
    plen = (len > 1480) ? 1480 : len;
    flen = (34 + plen < 60) ? 60 : 34 + plen;
    tl = 16'(20 + plen);
    for (int b = 0; b < 6; b++) f.push_back(dmac[47-8*b -: 8]);
    for (int b = 0; b < 6; b++) f.push_back(smac[47-8*b -: 8]);
    f.push_back(8'h08); f.push_back(8'h00); f.push_back(8'h45); f.push_back(8'h00);
    f.push_back(tl[15:8]); f.push_back(tl[7:0]); f.push_back(8'(id >> 8)); f.push_back(8'(id));
    f.push_back(8'h40); f.push_back(8'h00); f.push_back(8'h40); f.push_back(proto);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int b = 0; b < 4; b++) f.push_back(sip[31-8*b -: 8]);
    for (int b = 0; b < 4; b++) f.push_back(dip[31-8*b -: 8]);
    s = 0;
    for (int h = 14; h < 34; h += 2) s = s + {16'h0, f[h], f[h+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    f[24] = cs[15:8];
    f[25] = cs[7:0];
    for (int n = 0; n < plen; n++) f.push_back(8'(n + id));
    while (f.size() < flen) f.push_back(8'h00);
    foreach (f[i]) want_q.push_back(f[i]);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start on the chosen DUT, then records accepted bytes until busy drops.
  task automatic run(input bit w64, input bit rnd, input int stop_beat, input int max_cyc);
    logic [63:0] d, pd;
    logic [7:0] k, pk;
    logic v, l, b, pv, pl, rdy, pr, in_frame, after_last;
    int nb, gcur, cyc, since_last;
    got_q.delete(); fstart_q.delete(); gaps_q.delete();
    n_beats = 0; n_tlast = 0; stall_err = 0; holes = 0; busy_lag = -1; last_keep = '0;
    pv = 0; pr = 1; pd = '0; pk = '0; pl = 0; in_frame = 0; after_last = 0; gcur = 0; since_last = 0;
    nb = w64 ? 8 : 4;
    @(negedge clk);
    if (w64) s64 = 1'b1; else s32 = 1'b1;
    @(negedge clk);
    s32 = 1'b0; s64 = 1'b0;
    for (cyc = 0; cyc < max_cyc; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready = rdy;
      stop = 1'b0;
      d = w64 ? d64 : {32'h0, d32};
      k = w64 ? k64 : {4'h0, k32};
      v = w64 ? v64 : v32;
      l = w64 ? l64 : l32;
      b = w64 ? b64 : b32;
      if (after_last) since_last++;
      if (pv && !pr && (!v || d !== pd || k !== pk || l !== pl)) stall_err++;
      if (v) begin
        if (!in_frame) begin
          fstart_q.push_back(got_q.size());
          if (after_last) gaps_q.push_back(gcur);
          in_frame = 1;
        end
        if (rdy) begin
          for (int j = 0; j < nb; j++) if (k[nb-1-j]) got_q.push_back(d[8*(nb-j)-1 -: 8]);
          if (stop_beat > 0 && n_beats == stop_beat - 1) stop = 1'b1;
          n_beats++;
          if (l) begin
            n_tlast++; last_keep = k; in_frame = 0; after_last = 1; gcur = 0; since_last = 0;
          end
        end
      end else if (in_frame) begin
        holes++;
      end else if (after_last) begin
        gcur++;
      end
      if (n_tlast > 0 && !b) begin
        busy_lag = since_last;
        break;
      end
      pv = v; pr = rdy; pd = d; pk = k; pl = l;
      @(negedge clk);
    end
    chk("run_in_budget", 64'(cyc < max_cyc), 1);
    tready = 1'b1;
    stop = 1'b0;
  endtask

  task automatic chk_stream(input string nm);
    int errs;
    errs = 0;
    if (got_q.size() != want_q.size()) errs++;
    else foreach (got_q[i]) if (got_q[i] !== want_q[i]) errs++;
    chk({nm, "_nbytes"}, 64'(got_q.size()), 64'(want_q.size()));
    chk({nm, "_bytes"}, 64'(errs), 0);
  endtask

  vec_t vt[6];
  int seen, cnt;

  initial begin
    vt[0] = '{26,   15,  8'h0F, 16'h002E, 16'h26C8};
    vt[1] = '{0,    15,  8'h0F, 16'h0014, 16'h26E2};
    vt[2] = '{27,   16,  8'h08, 16'h002F, 16'h26C7};
    vt[3] = '{40,   19,  8'h0C, 16'h003C, 16'h26BA};
    vt[4] = '{1480, 379, 8'h0C, 16'h05DC, 16'h211A};
    vt[5] = '{1500, 379, 8'h0C, 16'h05DC, 16'h211A};

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(v32), 0);
    chk("rst_tlast", 64'(l32), 0);
    chk("rst_busy", 64'(b32), 0);
    chk("rst_tdata", 64'(d32), 0);
    chk("rst_tkeep", 64'(k32), 0);
    chk("rst_frames", 64'(fs32), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      pay_len = 11'(vt[i].len); num_frames = 16'd1; gap = 8'd0;
      want_q.delete();
      add_frame(vt[i].len, 0);
      run(0, 0, 0, 2000);
      chk($sformatf("v%0d_beats", i), 64'(n_beats), 64'(vt[i].beats));
      chk($sformatf("v%0d_lkeep", i), 64'(last_keep), 64'(vt[i].lkeep));
      chk($sformatf("v%0d_tlasts", i), 64'(n_tlast), 1);
      chk($sformatf("v%0d_totlen", i), 64'({got_q[16], got_q[17]}), 64'(vt[i].tot));
      chk($sformatf("v%0d_csum", i), 64'({got_q[24], got_q[25]}), 64'(vt[i].csum));
      chk($sformatf("v%0d_holes", i), 64'(holes), 0);
      chk($sformatf("v%0d_frames", i), 64'(fs32), 1);
      chk($sformatf("v%0d_busy_lag", i), 64'(busy_lag), 1);
      chk_stream($sformatf("v%0d", i));
      if (i == 0) begin
        chk("v0_word3", 64'({got_q[12], got_q[13], got_q[14], got_q[15]}), 64'h0800_4500);
        chk("v0_word4", 64'({got_q[16], got_q[17], got_q[18], got_q[19]}), 64'h002E_0000);
      end
    end

    do_reset();
    pay_len = 11'd27;
    want_q.delete(); add_frame(27, 0);
    run(1, 0, 0, 500);
    chk("w64_beats", 64'(n_beats), 8);
    chk("w64_lkeep", 64'(last_keep), 64'h00F8);
    chk("w64_byte60", 64'(got_q[60]), 64'h1A);
    chk("w64_frames", 64'(fs64), 1);
    chk_stream("w64");

    do_reset();
    pay_len = 11'd1480;
    want_q.delete(); add_frame(1480, 0);
    run(0, 1, 0, 4000);
    chk("rnd_stall", 64'(stall_err), 0);
    chk("rnd_tlasts", 64'(n_tlast), 1);
    chk("rnd_beats", 64'(n_beats), 379);
    chk_stream("rnd");

    do_reset();
    pay_len = 11'd26; num_frames = 16'd3; gap = 8'd4;
    want_q.delete(); add_frame(26, 0); add_frame(26, 1); add_frame(26, 2);
    run(0, 0, 0, 500);
    chk("burst_tlasts", 64'(n_tlast), 3);
    chk("burst_ngaps", 64'(gaps_q.size()), 2);
    foreach (gaps_q[g]) chk($sformatf("burst_gap%0d", g), 64'(gaps_q[g]), 5);
    foreach (fstart_q[f]) chk($sformatf("burst_id%0d", f),
      64'({got_q[fstart_q[f]+18], got_q[fstart_q[f]+19]}), 64'(f));
    chk("burst_busy_lag", 64'(busy_lag), 1);
    chk("burst_frames", 64'(fs32), 3);
    chk_stream("burst");

    do_reset();
    num_frames = 16'd1; gap = 8'd0;
    run(0, 0, 0, 500);
    @(negedge clk);
    s32 = 1'b1;
    @(negedge clk);
    s32 = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (v32) seen++;
      if (seen == 7) break;
      @(negedge clk);
    end
    chk("mr_reach_beat7", 64'(seen), 7);
    #2 rst = 1'b0;
    #1;
    chk("mr_tvalid", 64'(v32), 0);
    chk("mr_tlast", 64'(l32), 0);
    chk("mr_busy", 64'(b32), 0);
    chk("mr_tdata", 64'(d32), 0);
    chk("mr_tkeep", 64'(k32), 0);
    chk("mr_frames", 64'(fs32), 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (v32 || b32) cnt++;
    end
    chk("mr_no_resume", 64'(cnt), 0);
    want_q.delete(); add_frame(26, 0);
    run(0, 0, 0, 500);
    chk_stream("mr_restart");

    do_reset();
    num_frames = 16'd0; gap = 8'd0;
    want_q.delete(); add_frame(26, 0);
    run(0, 0, 3, 500);
    chk("cont_stop_tlasts", 64'(n_tlast), 1);
    chk("cont_stop_frames", 64'(fs32), 1);
    chk("cont_stop_busy_lag", 64'(busy_lag), 1);
    chk_stream("cont_stop");

    do_reset();
    want_q.delete(); add_frame(26, 0); add_frame(26, 1);
    run(0, 0, 20, 500);
    chk("cont2_tlasts", 64'(n_tlast), 2);
    chk("cont2_gap", 64'(gaps_q.size() > 0 ? gaps_q[0] : -1), 1);
    chk("cont2_frames", 64'(fs32), 2);
    chk_stream("cont2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
